rr_arb_2ph: RTL and testbench
=============================

RR_ARB_2PH -- requirements
Module: rr_arb_2ph

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of synchronizer flops on each asynchronous input; the legal range SHALL be 2..4.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 rstn  input  1  reset, asynchronous, active-low.
REQ-004 r1  input  1  port 1 two-phase request; each toggle is one new request; asynchronous to clk.
REQ-005 a1  output  1  port 1 two-phase acknowledge; one toggle per completed port 1 request.
REQ-006 r2  input  1  port 2 two-phase request; same rules as r1.
REQ-007 a2  output  1  port 2 two-phase acknowledge.
REQ-008 r  output  1  shared output channel two-phase request.
REQ-009 a  input  1  shared output channel two-phase acknowledge; asynchronous to clk.
REQ-010 gnt  output  2  one-hot current owner of the output channel: bit0 = port 1, bit1 = port 2; 00 when no owner.
REQ-011 busy  output  1  high while a transaction is outstanding on r/a.
REQ-012 err  output  1  sticky protocol-error flag.

Function
REQ-013 r1, r2 and a SHALL each pass through a SYNC_STAGES-deep flop chain before use; the synchronized values are r1s, r2s and as.
REQ-014 Port i SHALL be pending when (ris XOR ai) = 1.
REQ-015 The FSM SHALL have exactly two states: IDLE (no owner) and WAIT (transaction on r outstanding).
REQ-016 In IDLE with at least one port pending, the next edge SHALL toggle r, set gnt to the chosen port, set busy=1 and enter WAIT.
REQ-017 Selection SHALL be round-robin: if only one port is pending, grant it; if both are pending, grant the port other than last, where last is the most recently completed owner.
REQ-018 In WAIT, the arbiter SHALL hold r, gnt and the owner unchanged until as == r.
REQ-019 In WAIT with as == r, the next edge SHALL toggle a of the owner, update last to the owner, clear gnt to 00 and busy to 0, and return to IDLE.
REQ-020 At most one transaction SHALL be outstanding on r/a; a new grant SHALL NOT occur in the same cycle as a completion.
REQ-021 A second toggle on ri while port i is pending or owned violates the protocol; behaviour is undefined and need not be detected.
REQ-022 Latency from ri toggle to r toggle (IDLE, no contention) SHALL be SYNC_STAGES+1 rising edges; latency from a toggle to ai toggle SHALL be SYNC_STAGES+1 rising edges.
REQ-023 In IDLE, as != r (a spurious acknowledge toggle) SHALL set err to 1 on the next edge; err SHALL stay 1 until reset; the FSM SHALL otherwise ignore the event.
REQ-024 The non-owner port SHALL have its a output unchanged throughout a transaction.

Reset
REQ-025 When rstn=0, all state SHALL clear asynchronously: r=0, a1=0, a2=0, gnt=00, busy=0, err=0, FSM=IDLE, last=port 2 (port 1 wins the first tie), and all synchronizer flops=0.
REQ-026 Assertion of rstn mid-transaction SHALL abandon the transaction with no completion toggle; requesters and slave are reset by the same rstn.
REQ-027 Reset release SHALL be synchronized externally; the first FSM decision SHALL occur no earlier than the first rising edge after rstn=1.

Verification
REQ-028 Single request, SYNC_STAGES=2: r1 0->1 after reset; slave acks 10 cycles after r toggles -> r=1 at edge 3, gnt=01 and busy=1 until completion, a1=1 at edge 3 after the a toggle, r2/a2 untouched.
REQ-029 Tie: r1 and r2 toggle in the same cycle after reset -> port 1 granted first, then port 2; final r=0, a1=1, a2=1, and exactly two r toggles.
REQ-030 Fairness: both ports keep re-requesting immediately after each ack for 100 transactions -> grants strictly alternate and the per-port counts differ by at most 1.
REQ-031 Contention: r2 toggles while port 1 owns the channel -> port 2 is granted in the IDLE cycle right after port 1 completes, with gnt=00 for exactly one cycle in between.
REQ-032 Spurious ack: toggle a while in IDLE -> err=1 two to three edges later, no change on r, a1 or a2; err stays 1 until rstn=0.
REQ-033 Reset mid-WAIT: pulse rstn low for 5 ns while gnt=10 -> all outputs 0 immediately, then normal operation resumes and a fresh r1 toggle completes.

Source files
------------

// File: rtl/rr_arb_2ph.sv
// Two-port round-robin arbiter for two-phase (toggle) handshakes sharing one
// two-phase output channel. Async inputs are synchronized before use.

module rr_arb_2ph #(
    // Legal range 2..4.
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       r1,
    output logic       a1,
    input  logic       r2,
    output logic       a2,
    output logic       r,
    input  logic       a,
    output logic [1:0] gnt,
    output logic       busy,
    output logic       err
);

    typedef enum logic [0:0] {StIdle, StWait} state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] r1_sync_q, r1_sync_d;
    logic [SYNC_STAGES-1:0] r2_sync_q, r2_sync_d;
    logic [SYNC_STAGES-1:0] a_sync_q, a_sync_d;
    logic                   r_q, r_d;
    logic                   a1_q, a1_d;
    logic                   a2_q, a2_d;
    logic [1:0]             gnt_q, gnt_d;
    logic                   busy_q, busy_d;
    logic                   err_q, err_d;
    // 0: port 1 completed last, 1: port 2 completed last.
    logic                   last_q, last_d;

    logic r1_s, r2_s, a_s;
    logic pend1, pend2;

    assign r1_sync_d = {r1_sync_q[SYNC_STAGES-2:0], r1};
    assign r2_sync_d = {r2_sync_q[SYNC_STAGES-2:0], r2};
    assign a_sync_d  = {a_sync_q[SYNC_STAGES-2:0], a};

    assign r1_s = r1_sync_q[SYNC_STAGES-1];
    assign r2_s = r2_sync_q[SYNC_STAGES-1];
    assign a_s  = a_sync_q[SYNC_STAGES-1];

    assign pend1 = r1_s ^ a1_q;
    assign pend2 = r2_s ^ a2_q;

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        a1_d    = a1_q;
        a2_d    = a2_q;
        gnt_d   = gnt_q;
        busy_d  = busy_q;
        err_d   = err_q;
        last_d  = last_q;

        unique case (state_q)
            StIdle: begin
                // Acknowledge toggling with nothing outstanding.
                if (a_s != r_q) begin
                    err_d = 1'b1;
                end
                if (pend1 || pend2) begin
                    r_d     = ~r_q;
                    busy_d  = 1'b1;
                    state_d = StWait;
                    if (pend1 && (!pend2 || last_q)) begin
                        gnt_d = 2'b01;
                    end else begin
                        gnt_d = 2'b10;
                    end
                end
            end
            StWait: begin
                if (a_s == r_q) begin
                    if (gnt_q[0]) begin
                        a1_d = ~a1_q;
                    end else begin
                        a2_d = ~a2_q;
                    end
                    last_d  = gnt_q[1];
                    gnt_d   = 2'b00;
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= StIdle;
            r1_sync_q <= '0;
            r2_sync_q <= '0;
            a_sync_q  <= '0;
            r_q       <= 1'b0;
            a1_q      <= 1'b0;
            a2_q      <= 1'b0;
            gnt_q     <= 2'b00;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
            last_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            r1_sync_q <= r1_sync_d;
            r2_sync_q <= r2_sync_d;
            a_sync_q  <= a_sync_d;
            r_q       <= r_d;
            a1_q      <= a1_d;
            a2_q      <= a2_d;
            gnt_q     <= gnt_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
            last_q    <= last_d;
        end
    end

    assign r    = r_q;
    assign a1   = a1_q;
    assign a2   = a2_q;
    assign gnt  = gnt_q;
    assign busy = busy_q;
    assign err  = err_q;

endmodule

// File: tb/tb_rr_arb_2ph.sv
// Directed bench for rr_arb_2ph: per-cycle vector table plus hand-written
// sequences for tie, fairness, contention, spurious ack and mid-WAIT reset.

module tb_rr_arb_2ph;

    localparam int unsigned SyncStages = 2;

    logic       clk  = 1'b0;
    logic       rstn = 1'b0;
    logic       r1   = 1'b0;
    logic       r2   = 1'b0;
    logic       a    = 1'b0;
    logic       a1, a2, r, busy, err;
    logic [1:0] gnt;

    int n_vec     = 0;
    int n_err     = 0;
    int r_toggles = 0;

    typedef struct {
        logic       r1;
        logic       r2;
        logic       a;
        logic [6:0] exp;  // {r, a1, a2, gnt[1:0], busy, err}
    } vec_t;

    vec_t vecs[18];

    always #5 clk = ~clk;

    always @(r) r_toggles++;

    rr_arb_2ph #(
        .SYNC_STAGES(SyncStages)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .r1  (r1),
        .a1  (a1),
        .r2  (r2),
        .a2  (a2),
        .r   (r),
        .a   (a),
        .gnt (gnt),
        .busy(busy),
        .err (err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        r1   = 1'b0;
        r2   = 1'b0;
        a    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstn      = 1'b1;
        r_toggles = 0;
    endtask

    task automatic wait_busy(input logic lvl, input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (busy == lvl) ok = 1'b1;
            else tick();
        end
        check({name, "_wait"}, {31'b0, ok}, 32'd1);
    endtask

    task automatic grant_wait(input logic [1:0] exp_gnt, input string name);
        wait_busy(1'b1, name);
        check(name, {30'b0, gnt}, {30'b0, exp_gnt});
    endtask

    // Slave: acknowledge a few cycles after the grant, then wait for completion.
    task automatic finish_txn(input string name);
        repeat (3) tick();
        a = r;
        wait_busy(1'b0, {name, "_done"});
    endtask

    initial begin
        logic [1:0] g;
        logic [2:0] snap;
        int         cnt1;
        int         cnt2;

        // Port 1 alone, then both pending with port 1 last -> port 2, then port 1.
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 7'b000_00_00};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 7'b000_00_00};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 7'b100_01_10};
        vecs[3]  = '{1'b1, 1'b0, 1'b1, 7'b100_01_10};
        vecs[4]  = '{1'b1, 1'b0, 1'b1, 7'b100_01_10};
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 7'b110_00_00};
        vecs[6]  = '{1'b1, 1'b0, 1'b1, 7'b110_00_00};
        vecs[7]  = '{1'b0, 1'b1, 1'b1, 7'b110_00_00};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 7'b110_00_00};
        vecs[9]  = '{1'b0, 1'b1, 1'b1, 7'b010_10_10};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 7'b010_10_10};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 7'b010_10_10};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 7'b011_00_00};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 7'b111_01_10};
        vecs[14] = '{1'b0, 1'b1, 1'b1, 7'b111_01_10};
        vecs[15] = '{1'b0, 1'b1, 1'b1, 7'b111_01_10};
        vecs[16] = '{1'b0, 1'b1, 1'b1, 7'b101_00_00};
        vecs[17] = '{1'b0, 1'b1, 1'b1, 7'b101_00_00};

        repeat (2) @(posedge clk);
        #1;
        check("reset_state", {25'b0, r, a1, a2, gnt, busy, err}, 32'd0);
        rstn = 1'b1;
        repeat (2) tick();

        for (int i = 0; i < 18; i++) begin
            r1 = vecs[i].r1;
            r2 = vecs[i].r2;
            a  = vecs[i].a;
            tick();
            check($sformatf("vec%0d", i), {25'b0, r, a1, a2, gnt, busy, err},
                  {25'b0, vecs[i].exp});
        end

        // Tie straight after reset: port 1 first, then port 2.
        do_reset();
        r1 = 1'b1;
        r2 = 1'b1;
        grant_wait(2'b01, "tie_first");
        finish_txn("tie_first");
        grant_wait(2'b10, "tie_second");
        finish_txn("tie_second");
        repeat (3) tick();
        check("tie_final", {29'b0, r, a1, a2}, {29'b0, 3'b011});
        check("tie_r_toggles", r_toggles, 32'd2);

        // Fairness: each owner re-requests as soon as it is acknowledged.
        do_reset();
        cnt1 = 0;
        cnt2 = 0;
        r1   = ~r1;
        r2   = ~r2;
        for (int k = 0; k < 100; k++) begin
            wait_busy(1'b1, "fair_grant");
            g = gnt;
            check($sformatf("fair_alt%0d", k), {30'b0, g},
                  (k % 2 == 0) ? 32'd1 : 32'd2);
            a = r;
            wait_busy(1'b0, "fair_done");
            if (g[0]) begin
                cnt1++;
                r1 = ~r1;
            end else begin
                cnt2++;
                r2 = ~r2;
            end
        end
        check("fair_cnt1", cnt1, 32'd50);
        check("fair_cnt2", cnt2, 32'd50);

        // Contention: port 2 arrives while port 1 owns the channel.
        do_reset();
        r1 = 1'b1;
        grant_wait(2'b01, "cont_own");
        r2 = 1'b1;
        repeat (4) tick();
        a = r;
        wait_busy(1'b0, "cont_release");
        check("cont_gap", {30'b0, gnt}, 32'd0);
        tick();
        check("cont_next", {30'b0, gnt}, 32'd2);
        finish_txn("cont_second");

        // Spurious acknowledge toggle while idle.
        repeat (2) tick();
        check("spur_err_before", {31'b0, err}, 32'd0);
        snap = {r, a1, a2};
        a    = ~a;
        repeat (3) tick();
        check("spur_err", {31'b0, err}, 32'd1);
        check("spur_quiet", {29'b0, r, a1, a2}, {29'b0, snap});
        repeat (5) tick();
        check("spur_sticky", {31'b0, err}, 32'd1);
        do_reset();
        check("spur_cleared", {31'b0, err}, 32'd0);

        // Reset pulse while port 2 owns the channel.
        r2 = 1'b1;
        grant_wait(2'b10, "rst_grant");
        rstn = 1'b0;
        r2   = 1'b0;
        a    = 1'b0;
        #1;
        check("rst_async", {25'b0, r, a1, a2, gnt, busy, err}, 32'd0);
        #4;
        rstn = 1'b1;
        tick();
        r1 = 1'b1;
        grant_wait(2'b01, "rst_resume");
        finish_txn("rst_resume");
        check("rst_resume_acks", {30'b0, a1, a2}, 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
